debouncer_multi: RTL and testbench

//  N-channel parametrised debouncer for push-buttons, switches and other slow external inputs on the 16 MHz fabric clock.
//  - Each channel: synchroniser chain, then a stability counter.
//  - out_signal changes level only after the synchronised input holds the opposite level for STABLE_TICKS consecutive sample ticks.
//  - A shared prescaler sets the sample rate, so ms-scale debounce needs no wide counters.
//  - Optional one-clock rise/fall event pulses feed interrupt and edge logic.

---
 rtl/debouncer_multi.sv | 63 ++++++
 tb/tb_debouncer_multi.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/debouncer_multi.sv
// debouncer_multi: N-channel synchroniser + prescaled stability-counter debouncer.
// Define DEBOUNCE_EDGE_EN to build registered one-clock rise/fall pulses; otherwise they are tied low.
module debouncer_multi #(
  parameter int NUM_CH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE = 1,
  parameter int STABLE_TICKS = 40,
  parameter logic [NUM_CH-1:0] INIT_VAL = {NUM_CH{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] in_signal,
  output logic [NUM_CH-1:0] out_signal,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse
);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre;
  logic tick;
  logic [NUM_CH-1:0] chain [SYNC_STAGES];
  logic [NUM_CH-1:0] sync, state, state_nx;
  assign tick = pre == PW'(PRESCALE - 1);
  assign sync = chain[SYNC_STAGES-1];
  assign out_signal = state;
  always_ff @(posedge clk or posedge rst)
    if (rst) pre <= '0;
    else pre <= tick ? '0 : pre + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) chain[k] <= INIT_VAL;
    end else begin
      chain[0] <= in_signal;
      for (int k = 1; k < SYNC_STAGES; k++) chain[k] <= chain[k-1];
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic diff, flip;
    assign diff = sync[i] ^ state[i];
    assign flip = tick & diff & (cnt == CW'(STABLE_TICKS - 1));
    assign state_nx[i] = flip ? sync[i] : state[i];
    // Any agreeing tick restarts the count, so it never exceeds STABLE_TICKS-1.
    always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (tick) cnt <= (diff && !flip) ? cnt + 1'b1 : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= INIT_VAL;
    else state <= state_nx;
`ifdef DEBOUNCE_EDGE_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      rise_pulse <= state_nx & ~state;
      fall_pulse <= ~state_nx & state;
    end
`else
  assign rise_pulse = '0;
  assign fall_pulse = '0;
`endif
endmodule

// File: tb/tb_debouncer_multi.sv
// tb_debouncer_multi: directed and randomized checks of two debouncer_multi builds against a run-length model.
module tb_debouncer_multi;
  localparam int SS = 2;
  localparam int ST_A = 40;
  localparam int PS_B = 4;
  localparam int ST_B = 3;
`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] in_a = 8'hFF;
  logic [7:0] in_b = 8'h00;
  logic [7:0] out_a, rise_a, fall_a, out_b, rise_b, fall_b;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;

  debouncer_multi #(.NUM_CH(8), .SYNC_STAGES(SS), .PRESCALE(1), .STABLE_TICKS(ST_A), .INIT_VAL(8'hFF)) dut_a (
    .clk(clk), .rst(rst), .in_signal(in_a), .out_signal(out_a), .rise_pulse(rise_a), .fall_pulse(fall_a));
  debouncer_multi #(.NUM_CH(8), .SYNC_STAGES(SS), .PRESCALE(PS_B), .STABLE_TICKS(ST_B), .INIT_VAL(8'h00)) dut_b (
    .clk(clk), .rst(rst), .in_signal(in_b), .out_signal(out_b), .rise_pulse(rise_b), .fall_pulse(fall_b));

  // Reference: inputs reach the stability logic SS clocks late; a channel flips once it has seen
  // STABLE_TICKS consecutive sample ticks disagreeing with its current output.
  logic [7:0] ea_out, ea_rise, ea_fall, eb_out, eb_rise, eb_fall;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int run_a[8];
  int run_b[8];
  int ecnt;

  task automatic model_step();
    logic [7:0] sa, sb;
    if (rst) begin
      qa.delete();
      qb.delete();
      repeat (SS) begin
        qa.push_back(8'hFF);
        qb.push_back(8'h00);
      end
      ea_out = 8'hFF; eb_out = 8'h00;
      ea_rise = 0; ea_fall = 0; eb_rise = 0; eb_fall = 0;
      for (int i = 0; i < 8; i++) begin run_a[i] = 0; run_b[i] = 0; end
      ecnt = 0;
    end else begin
      sa = qa.pop_front(); qa.push_back(in_a);
      sb = qb.pop_front(); qb.push_back(in_b);
      ea_rise = 0; ea_fall = 0; eb_rise = 0; eb_fall = 0;
      for (int i = 0; i < 8; i++) begin
        run_a[i] = (sa[i] != ea_out[i]) ? run_a[i] + 1 : 0;
        if (run_a[i] == ST_A) begin
          run_a[i] = 0; ea_out[i] = sa[i];
          ea_rise[i] = EDGE & sa[i]; ea_fall[i] = EDGE & ~sa[i];
        end
      end
      if (ecnt % PS_B == PS_B - 1)
        for (int i = 0; i < 8; i++) begin
          run_b[i] = (sb[i] != eb_out[i]) ? run_b[i] + 1 : 0;
          if (run_b[i] == ST_B) begin
            run_b[i] = 0; eb_out[i] = sb[i];
            eb_rise[i] = EDGE & sb[i]; eb_fall[i] = EDGE & ~sb[i];
          end
        end
      ecnt++;
    end
  endtask

  always @(posedge clk or posedge rst) model_step();

  task automatic test_reset();
    rst = 1'b1; in_a = 8'hFF; in_b = 8'h00;
    repeat (3) @(negedge clk);
    tests++;
    if (out_a !== 8'hFF || out_b !== 8'h00) begin
      fails++; $display("FAIL reset_out a=%h b=%h required a=ff b=00", out_a, out_b);
    end
    tests++;
    if ({rise_a, fall_a, rise_b, fall_b} !== 32'h0) begin
      fails++; $display("FAIL reset_pulses got %h required 0", {rise_a, fall_a, rise_b, fall_b});
    end
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      tests++;
      if (out_a !== 8'hFF || rise_a !== 8'h00 || fall_a !== 8'h00) begin
        fails++; $display("FAIL reset_hold cyc=%0d out=%h rise=%h fall=%h required ff/00/00", k, out_a, rise_a, fall_a);
      end
    end
  endtask

  task automatic test_prescale();
    int hit = -1;
    in_b[1] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      tests++;
      if ({out_b, rise_b, fall_b} !== {eb_out, eb_rise, eb_fall}) begin
        fails++; $display("FAIL prescale_model edge=%0d got %h required %h", k, {out_b, rise_b, fall_b}, {eb_out, eb_rise, eb_fall});
      end
      if (hit < 0 && out_b[1]) hit = k;
    end
    tests++;
    if (hit < 0 || hit > 17) begin
      fails++; $display("FAIL prescale_latency rise at edge %0d required 1..17", hit);
    end
    for (int r = 0; r < 6; r++) begin
      in_b[2] = 1'b1;
      @(negedge clk);
      in_b[2] = 1'b0;
      repeat (4 + r % 3) begin
        @(negedge clk);
        tests++;
        if (out_b[2] !== 1'b0 || rise_b[2] !== 1'b0) begin
          fails++; $display("FAIL prescale_glitch rep=%0d out=%b rise=%b required 0/0", r, out_b[2], rise_b[2]);
        end
      end
    end
  endtask

  task automatic test_fall_latency();
    in_a[0] = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      tests++;
      if (out_a[0] !== (k < 42) || fall_a[0] !== (EDGE && k == 42) || rise_a !== 8'h00) begin
        fails++; $display("FAIL fall_latency edge=%0d out=%b fall=%b rise=%h required %b/%b/00",
                          k, out_a[0], fall_a[0], rise_a, k < 42, EDGE && k == 42);
      end
    end
  endtask

  task automatic test_glitch();
    for (int k = 1; k <= 80; k++) begin
      in_a[3] = (k <= 30 || k >= 36) ? 1'b0 : 1'b1;
      @(negedge clk);
      tests++;
      if (out_a[3] !== (k < 77) || fall_a[3] !== (EDGE && k == 77) || out_a[0] !== 1'b0) begin
        fails++; $display("FAIL glitch edge=%0d out3=%b fall3=%b out0=%b required %b/%b/0",
                          k, out_a[3], fall_a[3], out_a[0], k < 77, EDGE && k == 77);
      end
    end
  endtask

  task automatic test_simultaneous();
    in_a[0] = 1'b1; in_a[7] = 1'b0;
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      tests++;
      if (k < 42 && (out_a[0] !== 1'b0 || out_a[7] !== 1'b1 || rise_a !== 8'h00 || fall_a !== 8'h00)) begin
        fails++; $display("FAIL simul_early edge=%0d out=%h rise=%h fall=%h", k, out_a, rise_a, fall_a);
      end
      if (k == 42 && (out_a[0] !== 1'b1 || out_a[7] !== 1'b0 ||
                      rise_a !== (EDGE ? 8'h01 : 8'h00) || fall_a !== (EDGE ? 8'h80 : 8'h00))) begin
        fails++; $display("FAIL simul_flip out=%h rise=%h fall=%h required out[0]=1 out[7]=0 rise=%h fall=%h",
                          out_a, rise_a, fall_a, EDGE ? 8'h01 : 8'h00, EDGE ? 8'h80 : 8'h00);
      end
    end
    @(negedge clk);
    tests++;
    if (rise_a !== 8'h00 || fall_a !== 8'h00) begin
      fails++; $display("FAIL simul_pulse_width rise=%h fall=%h required 00/00", rise_a, fall_a);
    end
    in_a[0] = 1'b0; in_a[7] = 1'b1;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (out_a !== 8'hFF || rise_a !== 8'h00 || fall_a !== 8'h00) begin
      fails++; $display("FAIL async_reset out=%h rise=%h fall=%h required ff/00/00", out_a, rise_a, fall_a);
    end
    @(negedge clk);
    in_a = 8'hFF;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      tests++;
      if (out_a !== 8'hFF || rise_a !== 8'h00 || fall_a !== 8'h00) begin
        fails++; $display("FAIL post_reset cyc=%0d out=%h rise=%h fall=%h required ff/00/00", k, out_a, rise_a, fall_a);
      end
    end
  endtask

  task automatic test_random();
    int idx;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      tests++;
      if ({out_a, rise_a, fall_a} !== {ea_out, ea_rise, ea_fall}) begin
        fails++; $display("FAIL rand_a cyc=%0d got %h required %h", c, {out_a, rise_a, fall_a}, {ea_out, ea_rise, ea_fall});
      end
      tests++;
      if ({out_b, rise_b, fall_b} !== {eb_out, eb_rise, eb_fall}) begin
        fails++; $display("FAIL rand_b cyc=%0d got %h required %h", c, {out_b, rise_b, fall_b}, {eb_out, eb_rise, eb_fall});
      end
      rst = (c % 1000 == 999);
      if ($urandom_range(0, 15) == 0) begin
        idx = $urandom_range(0, 7);
        in_a[idx] = ~in_a[idx];
      end
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, 7);
        in_b[idx] = ~in_b[idx];
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_fall_latency();
    test_glitch();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
